// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int DATA_W_DEF   = 8;
  localparam int PRESCALE_MIN = 8;

  // Zero-extending the data does not change its XOR reduction.
  function automatic logic parity_bit(input logic [31:0] data, input logic par_typ);
    return (^data) ^ par_typ;
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// RX line, config, sampler and output strobes of the UART receive controller.
interface uart_rx_fsm_if
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = 6
);
  logic                  RX_in;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] prescale;
  logic                  sampled_bit;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  dat_samp_en;
  logic [DATA_W-1:0]     P_DATA;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_in, PAR_EN, PAR_TYP, prescale, sampled_bit,
    input  edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_in, PAR_EN, PAR_TYP, prescale, sampled_bit,
    output edge_cnt, bit_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and data bit index counter for the UART receiver.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  bit_inc,
  input  logic                  bit_clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  bit_done
);

  assign bit_done = (edge_cnt == (prescale - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
    end else if (en) begin
      edge_cnt <= bit_done ? '0 : edge_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (bit_clr) begin
      bit_cnt <= '0;
    end else if (bit_inc) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detect, LSB-first deserialise,
// parity/stop checks and one-cycle result strobes.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PRESCALE_W = 6
) (
  input logic          CLK,
  input logic          RST,
  uart_rx_fsm_if.slave bus
);

  rx_state_e             state;
  rx_state_e             next_state;
  logic                  rx_prev;
  logic                  armed;
  logic                  cfg_par_en;
  logic                  cfg_par_typ;
  logic [PRESCALE_W-1:0] cfg_prescale;
  logic [PRESCALE_W-1:0] presc_eff;
  logic [DATA_W-1:0]     shreg;
  logic                  frame_bad;
  logic [DATA_W-1:0]     p_data;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  logic                  start_det;
  logic                  cnt_en;
  logic                  bit_done;
  logic                  bit_inc;
  logic                  bit_clr;
  logic                  shift_en;
  logic                  par_fail;
  logic                  stop_fail;
  logic                  load;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;

  // armed stays low until the line has been seen high, so a line held low
  // across reset release cannot fake a falling edge.
  assign start_det = (state == IDLE) && armed && rx_prev && !bus.RX_in;
  assign cnt_en    = (state != IDLE) || start_det;
  assign presc_eff = (state == IDLE) ? bus.prescale : cfg_prescale;

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .en       (cnt_en),
    .clr      (!cnt_en),
    .bit_inc  (bit_inc),
    .bit_clr  (bit_clr),
    .prescale (presc_eff),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    bit_inc    = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    par_fail   = 1'b0;
    stop_fail  = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        bit_clr = 1'b1;
        if (start_det) next_state = START;
      end
      START: begin
        if (bit_done) begin
          if (bus.sampled_bit) begin
            next_state = IDLE;
          end else begin
            next_state = DATA;
            bit_clr    = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_en = 1'b1;
          if (bit_cnt == 4'(DATA_W - 1)) begin
            next_state = cfg_par_en ? PARITY : STOP;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          next_state = STOP;
          par_fail   = (bus.sampled_bit != parity_bit(32'(shreg), cfg_par_typ));
        end
      end
      STOP: begin
        if (bit_done) begin
          next_state = IDLE;
          if (!bus.sampled_bit) begin
            stop_fail = 1'b1;
          end else if (!frame_bad) begin
            load = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_prev      <= 1'b1;
      armed        <= 1'b0;
      cfg_par_en   <= 1'b0;
      cfg_par_typ  <= 1'b0;
      cfg_prescale <= '0;
      shreg        <= '0;
      frame_bad    <= 1'b0;
      p_data       <= '0;
      data_valid   <= 1'b0;
      par_err      <= 1'b0;
      stp_err      <= 1'b0;
    end else begin
      rx_prev <= bus.RX_in;
      armed   <= armed | bus.RX_in;
      if (start_det) begin
        cfg_par_en   <= bus.PAR_EN;
        cfg_par_typ  <= bus.PAR_TYP;
        cfg_prescale <= bus.prescale;
        frame_bad    <= 1'b0;
      end else if (par_fail) begin
        frame_bad <= 1'b1;
      end
      if (shift_en) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (bit_cnt == 4'(i)) shreg[i] <= bus.sampled_bit;
        end
      end
      if (load) p_data <= shreg;
      data_valid <= load;
      par_err    <= par_fail;
      stp_err    <= stop_fail;
    end
  end

  assign bus.edge_cnt    = edge_cnt;
  assign bus.bit_cnt     = bit_cnt;
  assign bus.dat_samp_en = (state != IDLE);
  assign bus.P_DATA      = p_data;
  assign bus.data_valid  = data_valid;
  assign bus.par_err     = par_err;
  assign bus.stp_err     = stp_err;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: directed frames, expected strobes queued
// with their cycle, a negedge monitor pops and compares.
module tb_uart_rx_fsm;
  import uart_rx_pkg::*;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
  localparam int K_VALID    = 0;
  localparam int K_PAR      = 1;
  localparam int K_STP      = 2;
  localparam int K_NONE     = -1;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic CLK;
  logic RST;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];
  exp_t mon_e;
  int   mon_n;
  int   mon_kind;

  uart_rx_fsm_if #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) bus ();

  uart_rx_fsm #(.DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Ideal sampler: the bench holds each bit for a full bit period.
  assign bus.sampled_bit = bus.RX_in;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      mon_n = int'(bus.data_valid) + int'(bus.par_err) + int'(bus.stp_err);
      if (mon_n > 0) begin
        if (mon_n > 1) check("single_strobe", 32'(mon_n), 32'd1);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe dv=%0b par=%0b stp=%0b at cyc %0d, none expected",
                   bus.data_valid, bus.par_err, bus.stp_err, cyc);
        end else begin
          mon_e    = q.pop_front();
          mon_kind = bus.data_valid ? K_VALID : (bus.par_err ? K_PAR : K_STP);
          check("strobe_kind", 32'(mon_kind), 32'(mon_e.kind));
          check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (mon_e.kind == K_VALID) check("p_data_on_valid", 32'(bus.P_DATA), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int p);
    bus.RX_in = b;
    tick(p);
  endtask

  // One frame starting now; optionally corrupts the live config after the
  // start-detect cycle to prove it is latched.
  task automatic send(input logic [7:0] d, input int p, input logic pe, input logic pt,
                      input logic pbit, input logic sbit, input int kind, input logic scr);
    exp_t e;
    int   t;
    t               = cyc;
    bus.PAR_EN      = pe;
    bus.PAR_TYP     = pt;
    bus.prescale    = 6'(p);
    if (kind != K_NONE) begin
      e.kind = kind;
      e.data = d;
      e.cyc  = t + (kind == K_PAR ? (9 + int'(pe)) * p : (10 + int'(pe)) * p);
      q.push_back(e);
    end
    bus.RX_in = 1'b0;
    tick(1);
    if (scr) begin
      bus.PAR_EN   = !pe;
      bus.PAR_TYP  = !pt;
      bus.prescale = 6'(p + 2);
    end
    tick(p - 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(sbit, p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    bus.RX_in    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.prescale = 6'd8;
    tick(3);
    check("rst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    check("rst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    check("rst_p_data", 32'(bus.P_DATA), 32'd0);
    check("rst_strobes", {29'd0, bus.data_valid, bus.par_err, bus.stp_err}, 32'd0);
    check("rst_samp_en", 32'(bus.dat_samp_en), 32'd0);
    RST = 1'b0;
    tick(4);

    // Plain 8N1 frame; config scrambled mid-frame.
    send(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 1'b1);
    tick(4);
    check("p_data_a5", 32'(bus.P_DATA), 32'hA5);

    // Even parity expected 0, sent 1.
    send(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, K_PAR, 1'b0);
    tick(4);
    check("p_data_hold_par", 32'(bus.P_DATA), 32'hA5);

    // Start glitch: low 3 cycles, sampled high at the start boundary.
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    bus.RX_in    = 1'b0;
    tick(3);
    bus.RX_in = 1'b1;
    tick(4);
    @(negedge CLK);
    check("glitch_samp_en_t7", 32'(bus.dat_samp_en), 32'd1);
    check("glitch_edge_t7", 32'(bus.edge_cnt), 32'd7);
    @(negedge CLK);
    check("glitch_samp_en_t8", 32'(bus.dat_samp_en), 32'd0);
    check("glitch_edge_t8", 32'(bus.edge_cnt), 32'd0);
    tick(10);

    // Stop bit sampled low.
    send(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, K_STP, 1'b0);
    bus.RX_in = 1'b1;
    tick(4);
    check("p_data_hold_stp", 32'(bus.P_DATA), 32'hA5);

    // Back-to-back odd-parity frames, no idle gap.
    send(8'h55, 16, 1'b1, 1'b1, 1'b1, 1'b1, K_VALID, 1'b0);
    send(8'hAA, 16, 1'b1, 1'b1, 1'b1, 1'b1, K_VALID, 1'b0);
    tick(4);
    check("p_data_aa", 32'(bus.P_DATA), 32'hAA);

    // Reset at edge 3 of data bit 4, line low across reset release.
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    bus.RX_in = 1'b0;
    tick(3);
    check("mid_edge_cnt", 32'(bus.edge_cnt), 32'd3);
    check("mid_bit_cnt", 32'(bus.bit_cnt), 32'd4);
    RST = 1'b1;
    #1;
    check("mrst_edge_cnt", 32'(bus.edge_cnt), 32'd0);
    check("mrst_bit_cnt", 32'(bus.bit_cnt), 32'd0);
    check("mrst_p_data", 32'(bus.P_DATA), 32'd0);
    check("mrst_samp_en", 32'(bus.dat_samp_en), 32'd0);
    tick(2);
    RST = 1'b0;
    tick(20);
    check("no_rearm_low", 32'(bus.dat_samp_en), 32'd0);
    bus.RX_in = 1'b1;
    tick(3);
    send(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, K_VALID, 1'b1);
    tick(20);
    check("p_data_81", 32'(bus.P_DATA), 32'h81);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
